psk_stream_mod: RTL and testbench

Streaming, parametrised PSK symbol mapper that replaces the fixed combinational BPSK mapper in the transmit chain. It accepts one N-bit codeword from the Hamming or BCH encoder per handshake and serialises it into signed I/Q symbols, LSB first, one symbol per cycle, with backpressure. It supports a run-time BPSK/QPSK mode and sits between the channel encoder and the channel/noise model.

---
 rtl/psk_pkg.sv | 25 ++
 rtl/psk_bit_map.sv | 20 ++
 rtl/psk_stream_mod.sv | 143 ++++++++++++++
 tb/tb_psk_stream_mod.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared types, amplitude constants and symbol-count helper for the PSK mapper.
package psk_pkg;

   typedef enum logic {
      MODE_BPSK = 1'b0,
      MODE_QPSK = 1'b1
   } psk_mode_e;

   // Widest supported amplitude; consumers truncate with SYM_W'(...)
   localparam int unsigned MAX_SYM_W = 32;

   // +1, -1 and 0 in two's complement; truncation keeps their meaning at any width >= 2
   localparam logic [MAX_SYM_W-1:0] SYM_PLUS  = 32'h0000_0001;
   localparam logic [MAX_SYM_W-1:0] SYM_MINUS = 32'hFFFF_FFFF;
   localparam logic [MAX_SYM_W-1:0] SYM_ZERO  = 32'h0000_0000;

   // Number of symbols one n-bit codeword produces in the given mode
   function automatic int unsigned sym_count(input int unsigned n, input psk_mode_e mode);
      if (mode == MODE_QPSK) begin
         return (n + 1) / 2;
      end
      return n;
   endfunction

endpackage

// File: rtl/psk_bit_map.sv
// Combinational bit-to-amplitude mapper: 0 -> +1, 1 -> -1, pad -> 0.
module psk_bit_map
   import psk_pkg::*;
#(
   parameter int unsigned SYM_W = 2
) (
   input  logic             data_bit,
   input  logic             pad,
   output logic [SYM_W-1:0] amp_c
);

   // Pad dominates so a missing Q bit on odd-length QPSK words transmits nothing
   always_comb begin
      amp_c = SYM_W'(SYM_ZERO);
      if (!pad) begin
         amp_c = data_bit ? SYM_W'(SYM_MINUS) : SYM_W'(SYM_PLUS);
      end
   end

endmodule

// File: rtl/psk_stream_mod.sv
// Streaming BPSK/QPSK symbol mapper: serialises N-bit codewords LSB first with backpressure.
module psk_stream_mod
   import psk_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned SYM_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_data,
   input  logic             in_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SYM_W-1:0] out_i,
   output logic [SYM_W-1:0] out_q,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int unsigned CNT_W = $clog2(N + 1);
   localparam logic        N_ODD = ((N % 2) == 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]       state, state_n;
   logic [N-1:0]     shreg, shreg_n;
   logic [CNT_W-1:0] sym_left, sym_left_n;
   psk_mode_e        mode_q, mode_n;
   logic [SYM_W-1:0] out_i_n, out_q_n;
   logic             out_valid_n, out_last_n;

   logic             accept, xfer, take;
   logic [N-1:0]     src_bits;
   psk_mode_e        src_mode;
   logic [CNT_W-1:0] cnt_next;
   logic             pad_q;
   logic [SYM_W-1:0] map_i_c, map_q_c;

   // Handshake: a new word may enter when nothing is held or the last symbol is leaving
   assign in_ready = !out_valid | (out_ready & out_last);
   assign accept   = in_valid & in_ready;
   assign xfer     = out_valid & out_ready;

   // Source of the next symbol: the incoming word on accept, else the remaining bits
   always_comb begin
      src_bits = shreg;
      src_mode = mode_q;
      cnt_next = sym_left - CNT_W'(1);
      if (accept) begin
         src_bits = in_data;
         src_mode = psk_mode_e'(in_mode);
         cnt_next = CNT_W'(sym_count(N, psk_mode_e'(in_mode)));
      end
      pad_q = (src_mode == MODE_BPSK) | (N_ODD & (cnt_next == CNT_W'(1)));
   end

   psk_bit_map #(.SYM_W(SYM_W)) u_map_i (
      .data_bit (src_bits[0]),
      .pad      (1'b0),
      .amp_c    (map_i_c)
   );

   psk_bit_map #(.SYM_W(SYM_W)) u_map_q (
      .data_bit (src_bits[1]),
      .pad      (pad_q),
      .amp_c    (map_q_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      sym_left_n  = sym_left;
      mode_n      = mode_q;
      out_i_n     = out_i;
      out_q_n     = out_q;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      take        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               take = 1'b1;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (!out_last || in_valid) begin
                  take = 1'b1;
               end else begin
                  state_n     = ST_IDLE;
                  out_valid_n = 1'b0;
                  out_last_n  = 1'b0;
                  out_i_n     = '0;
                  out_q_n     = '0;
                  sym_left_n  = '0;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (take) begin
         state_n     = ST_SEND;
         shreg_n     = (src_mode == MODE_QPSK) ? (src_bits >> 2) : (src_bits >> 1);
         sym_left_n  = cnt_next;
         mode_n      = src_mode;
         out_valid_n = 1'b1;
         out_last_n  = (cnt_next == CNT_W'(1));
         out_i_n     = map_i_c;
         out_q_n     = map_q_c;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         sym_left  <= '0;
         mode_q    <= MODE_BPSK;
         out_i     <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         sym_left  <= sym_left_n;
         mode_q    <= mode_n;
         out_i     <= out_i_n;
         out_q     <= out_q_n;
         out_valid <= out_valid_n;
         out_last  <= out_last_n;
      end
   end

endmodule

// File: tb/tb_psk_stream_mod.sv
// Scoreboard bench for psk_stream_mod: N=8 and N=15 instances, SYM_W=2.
module tb_psk_stream_mod;

   typedef struct packed {
      logic [1:0] i;
      logic [1:0] q;
      logic       last;
   } sym_t;

   logic             clk;
   logic             rst_n;
   logic [1:0][14:0] in_data;
   logic [1:0]       in_mode;
   logic [1:0]       in_valid;
   logic [1:0]       in_ready;
   logic [1:0][1:0]  out_i;
   logic [1:0][1:0]  out_q;
   logic [1:0]       out_valid;
   logic [1:0]       out_last;
   logic [1:0]       out_ready;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int xfer_cnt [2];
   int last_xfer_cyc [2];
   bit stall [2];
   bit rnd_ready = 0;
   sym_t exp_q0[$];
   sym_t exp_q1[$];
   int   ir_log[$];

   psk_stream_mod #(.N(8), .SYM_W(2)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[0][7:0]),
      .in_mode   (in_mode[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .out_i     (out_i[0]),
      .out_q     (out_q[0]),
      .out_valid (out_valid[0]),
      .out_last  (out_last[0]),
      .out_ready (out_ready[0])
   );

   psk_stream_mod #(.N(15), .SYM_W(2)) u_dut15 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[1]),
      .in_mode   (in_mode[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .out_i     (out_i[1]),
      .out_q     (out_q[1]),
      .out_valid (out_valid[1]),
      .out_last  (out_last[1]),
      .out_ready (out_ready[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] amp(input logic b);
      return b ? 2'b11 : 2'b01;
   endfunction

   // Reference: expected symbol list of one codeword, straight from the mapping rules
   function automatic void model(input int d, input logic [14:0] data, input int n, input bit qpsk);
      sym_t s;
      int   ns;
      ns = qpsk ? (n + 1) / 2 : n;
      for (int k = 0; k < ns; k++) begin
         if (qpsk) begin
            s.i = amp(data[2*k]);
            s.q = (2*k + 1 < n) ? amp(data[2*k+1]) : 2'b00;
         end else begin
            s.i = amp(data[k]);
            s.q = 2'b00;
         end
         s.last = (k == ns - 1);
         if (d == 0) exp_q0.push_back(s);
         else        exp_q1.push_back(s);
      end
   endfunction

   // Downstream ready: random, stalled or always-on
   initial begin
      out_ready = '0;
      forever begin
         @(negedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (stall[d])       out_ready[d] = 1'b0;
            else if (rnd_ready) out_ready[d] = ($urandom_range(3) != 0);
            else                out_ready[d] = 1'b1;
         end
      end
   end

   // Monitor: compares every transferred symbol and checks stall behaviour
   task automatic monitor(input int d);
      logic       pv;
      logic [4:0] prev, cur;
      sym_t       e;
      pv = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            pv = 1'b0;
            continue;
         end
         cur = {out_i[d], out_q[d], out_last[d]};
         if (pv) begin
            checks++;
            if (cur !== prev) begin
               failures++;
               $display("FAIL stall_hold dut%0d got=%b expected=%b", d, cur, prev);
            end
         end
         if (out_valid[d] && !out_ready[d]) begin
            checks++;
            if (in_ready[d] !== 1'b0) begin
               failures++;
               $display("FAIL stall_in_ready dut%0d got=%b expected=0", d, in_ready[d]);
            end
            pv = 1'b1;
            prev = cur;
         end else begin
            pv = 1'b0;
         end
         if (d == 0 && in_ready[0]) ir_log.push_back(cyc);
         if (out_valid[d] && out_ready[d]) begin
            checks++;
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
               failures++;
               $display("FAIL unexpected_sym dut%0d got=%b expected=none", d, cur);
            end else begin
               e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               if (cur !== e) begin
                  failures++;
                  $display("FAIL symbol dut%0d got i=%b q=%b last=%b expected i=%b q=%b last=%b",
                           d, out_i[d], out_q[d], out_last[d], e.i, e.q, e.last);
               end
            end
            xfer_cnt[d]++;
            last_xfer_cyc[d] = cyc;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   // Offer one word, wait (bounded) for acceptance, then check first-symbol latency
   task automatic send_word(input int d, input logic [14:0] data, input bit qpsk);
      int n;
      bit done;
      n = (d == 0) ? 8 : 15;
      done = 1'b0;
      in_data[d]  = data;
      in_mode[d]  = qpsk;
      in_valid[d] = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         #4;
         if (in_ready[d]) begin
            model(d, data, n, qpsk);
            acc_cyc = cyc;
            done = 1'b1;
         end
         @(negedge clk);
      end
      in_valid[d] = 1'b0;
      in_mode[d]  = 1'($urandom);
      in_data[d]  = 15'($urandom);
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL accept_timeout dut%0d got=no_accept expected=accept", d);
      end else if (out_valid[d] !== 1'b1) begin
         failures++;
         $display("FAIL first_latency dut%0d got out_valid=%b expected=1", d, out_valid[d]);
      end
   endtask

   task automatic wait_drain(input int d);
      for (int k = 0; k < 2000; k++) begin
         if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) break;
         @(negedge clk);
      end
      checks++;
      if ((d == 0 ? exp_q0.size() : exp_q1.size()) != 0) begin
         failures++;
         $display("FAIL drain_timeout dut%0d got pending=%0d expected=0", d,
                  (d == 0 ? exp_q0.size() : exp_q1.size()));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_xfers(input int d, input int target);
      for (int k = 0; k < 200 && xfer_cnt[d] < target; k++) @(negedge clk);
      checks++;
      if (xfer_cnt[d] < target) begin
         failures++;
         $display("FAIL xfer_timeout dut%0d got=%0d expected=%0d", d, xfer_cnt[d], target);
      end
   endtask

   initial begin
      int c0, a_cyc, n_ir;
      bit ir_ok;
      rst_n = 1'b0;
      in_data = '0;
      in_mode = '0;
      in_valid = '0;
      xfer_cnt[0] = 0; xfer_cnt[1] = 0;
      last_xfer_cyc[0] = 0; last_xfer_cyc[1] = 0;
      stall[0] = 0; stall[1] = 0;

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({out_valid[d], out_last[d], out_i[d], out_q[d], in_ready[d]} !== 7'b00_0000_1) begin
            failures++;
            $display("FAIL reset_state dut%0d got v=%b l=%b i=%b q=%b rdy=%b expected 0,0,00,00,1",
                     d, out_valid[d], out_last[d], out_i[d], out_q[d], in_ready[d]);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed words
      send_word(0, 15'h00A6, 1'b0);
      wait_drain(0);
      send_word(0, 15'h00A6, 1'b1);
      wait_drain(0);
      send_word(1, 15'h7FFF, 1'b1);
      wait_drain(1);
      send_word(1, 15'h2C35, 1'b0);
      wait_drain(1);

      // Back-to-back: 16 gapless symbols, in_ready only at the two accepts
      ir_log.delete();
      c0 = xfer_cnt[0];
      send_word(0, 15'h005B, 1'b0);
      a_cyc = acc_cyc;
      send_word(0, 15'h00C3, 1'b0);
      wait_drain(0);
      checks++;
      if (xfer_cnt[0] - c0 != 16 || last_xfer_cyc[0] - a_cyc != 16) begin
         failures++;
         $display("FAIL b2b_gapless got syms=%0d span=%0d expected syms=16 span=16",
                  xfer_cnt[0] - c0, last_xfer_cyc[0] - a_cyc);
      end
      n_ir = 0;
      ir_ok = 1'b1;
      foreach (ir_log[k]) begin
         if (ir_log[k] >= a_cyc && ir_log[k] <= a_cyc + 15) begin
            n_ir++;
            if (ir_log[k] != a_cyc && ir_log[k] != a_cyc + 8) ir_ok = 1'b0;
         end
      end
      checks++;
      if (n_ir != 2 || !ir_ok) begin
         failures++;
         $display("FAIL b2b_in_ready got high_cycles=%0d placed_ok=%0d expected=2,1", n_ir, ir_ok);
      end

      // Backpressure: three stalled cycles on symbol 3
      c0 = xfer_cnt[0];
      send_word(0, 15'h0039, 1'b0);
      wait_xfers(0, c0 + 2);
      stall[0] = 1;
      repeat (3) @(negedge clk);
      stall[0] = 0;
      wait_drain(0);
      checks++;
      if (xfer_cnt[0] - c0 != 8) begin
         failures++;
         $display("FAIL stall_count got=%0d expected=8", xfer_cnt[0] - c0);
      end

      // Reset mid-stream after symbol 2
      c0 = xfer_cnt[0];
      send_word(0, 15'h00F0, 1'b0);
      wait_xfers(0, c0 + 2);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid[0], out_last[0], out_i[0], out_q[0], in_ready[0]} !== 7'b00_0000_1) begin
         failures++;
         $display("FAIL async_reset got v=%b l=%b i=%b q=%b rdy=%b expected 0,0,00,00,1",
                  out_valid[0], out_last[0], out_i[0], out_q[0], in_ready[0]);
      end
      exp_q0.delete();
      exp_q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_ready got=%b expected=1", in_ready[0]);
      end
      send_word(0, 15'h0081, 1'b1);
      wait_drain(0);

      // Randomised traffic under random backpressure
      rnd_ready = 1;
      for (int w = 0; w < 40; w++) begin
         send_word(0, 15'($urandom), 1'($urandom));
         repeat ($urandom_range(2)) @(negedge clk);
      end
      wait_drain(0);
      for (int w = 0; w < 12; w++) begin
         send_word(1, 15'($urandom), 1'($urandom));
         repeat ($urandom_range(2)) @(negedge clk);
      end
      wait_drain(1);
      rnd_ready = 0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
